// File: rtl/branch_predict_unit_if.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_if
// Bundles the decode-side prediction port, the execute-side resolution port
// and the debug performance counters of branch_predict_unit.
//   master : pipeline side (drives decode/execute fields, reads results)
//   slave  : predictor side (branch_predict_unit)
// Decode  : dec_valid, dec_pc, dec_imm -> pred_taken, pred_target
// Execute : ex_valid, ex_pc, ex_imm, rs1_val, rs2_val, branch_control,
//           ex_pred_taken -> pc_update_control, pc_update_val,
//           ignore_curr_inst
// Debug   : perf_branches, perf_mispredicts
// ---------------------------------------------------------------------------
interface branch_predict_unit_if #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 16
);
    logic              dec_valid;
    logic [XLEN-1:0]   dec_pc;
    logic [XLEN-1:0]   dec_imm;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [2:0]        branch_control;
    logic              ex_pred_taken;
    logic              pc_update_control;
    logic [XLEN-1:0]   pc_update_val;
    logic              ignore_curr_inst;

    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispredicts;

    modport master (
        output dec_valid, dec_pc, dec_imm,
        input  pred_taken, pred_target,
        output ex_valid, ex_pc, ex_imm, rs1_val, rs2_val, branch_control,
               ex_pred_taken,
        input  pc_update_control, pc_update_val, ignore_curr_inst,
        input  perf_branches, perf_mispredicts
    );

    modport slave (
        input  dec_valid, dec_pc, dec_imm,
        output pred_taken, pred_target,
        input  ex_valid, ex_pc, ex_imm, rs1_val, rs2_val, branch_control,
               ex_pred_taken,
        output pc_update_control, pc_update_val, ignore_curr_inst,
        output perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// Bimodal branch predictor plus execute-stage branch resolver.
//   - Decode: zero-latency lookup of a 2-bit saturating counter BHT gives
//     pred_taken / pred_target.
//   - Execute: resolves the branch, trains the BHT, redirects fetch only on
//     a mispredict and then squashes FLUSH_CYCLES wrong-path slots.
//   - Saturating debug counters of resolved branches and mispredicts.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous reset, active low
//   bp    : branch_predict_unit_if.slave (decode, execute and perf fields)
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    branch_predict_unit_if.slave bp
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // branch_control encodings shared with the rest of the processor
    localparam logic [2:0] BR_NOP = 3'd0;
    localparam logic [2:0] BEQ    = 3'd1;
    localparam logic [2:0] BNE    = 3'd2;
    localparam logic [2:0] BLT    = 3'd3;
    localparam logic [2:0] BGE    = 3'd4;
    localparam logic [2:0] BLTU   = 3'd5;
    localparam logic [2:0] BGEU   = 3'd6;

    localparam logic [1:0]        CTR_RESET = 2'b01;
    localparam logic [PERF_W-1:0] PERF_MAX  = '1;

    typedef enum logic {IDLE, FLUSH} flush_state_t;

    function automatic logic [IDX_W-1:0] bht_idx(input logic [XLEN-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [1:0] sat_ctr_update(input logic [1:0] ctr,
                                                  input logic       up);
        if (up)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    function automatic logic [PERF_W-1:0] perf_sat_inc(input logic [PERF_W-1:0] v);
        return (v == PERF_MAX) ? v : v + 1'b1;
    endfunction

    logic [1:0]          bht [BHT_ENTRIES];
    flush_state_t        state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PERF_W-1:0]   perf_br_q, perf_mis_q;

    logic [IDX_W-1:0]    idx_dec_p0, idx_ex_p0;
    logic signed [XLEN-1:0] rs1_s_p0, rs2_s_p0;
    logic                actual_p0, code_ok_p0, effective_p0, mispredict_p0;

    // ---- decode stage: prediction lookup ----
    assign idx_dec_p0     = bht_idx(bp.dec_pc);
    assign bp.pred_taken  = bht[idx_dec_p0][1] & bp.dec_valid;
    assign bp.pred_target = bp.pred_taken ? bp.dec_pc + bp.dec_imm
                                          : bp.dec_pc + XLEN'(4);

    // ---- execute stage: resolution ----
    assign rs1_s_p0  = bp.rs1_val;
    assign rs2_s_p0  = bp.rs2_val;
    assign idx_ex_p0 = bht_idx(bp.ex_pc);

    always_comb begin
        actual_p0  = 1'b0;
        code_ok_p0 = 1'b1;
        case (bp.branch_control)
            BEQ:     actual_p0 = (bp.rs1_val == bp.rs2_val);
            BNE:     actual_p0 = (bp.rs1_val != bp.rs2_val);
            BLT:     actual_p0 = (rs1_s_p0 <  rs2_s_p0);
            BGE:     actual_p0 = (rs1_s_p0 >= rs2_s_p0);
            BLTU:    actual_p0 = (bp.rs1_val <  bp.rs2_val);
            BGEU:    actual_p0 = (bp.rs1_val >= bp.rs2_val);
            default: code_ok_p0 = 1'b0; // BR_NOP and unassigned codes
        endcase
    end

    // Wrong-path slots inside a flush are neither resolved nor counted.
    assign effective_p0  = bp.ex_valid & ~bp.ignore_curr_inst & code_ok_p0
                         & (bp.branch_control != BR_NOP);
    assign mispredict_p0 = effective_p0 & (actual_p0 != bp.ex_pred_taken);

    assign bp.pc_update_control = mispredict_p0;
    assign bp.pc_update_val     = !mispredict_p0 ? '0 :
                                  actual_p0      ? bp.ex_pc + bp.ex_imm
                                                 : bp.ex_pc + XLEN'(4);

    // ---- registered state: BHT training ----
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= CTR_RESET;
        end else if (effective_p0) begin
            bht[idx_ex_p0] <= sat_ctr_update(bht[idx_ex_p0], actual_p0);
        end
    end

    // ---- registered state: flush FSM ----
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict_p0) begin
                    state_d = FLUSH;
                    cnt_d   = 4'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                // cnt holds the squash slots left including this one
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bp.ignore_curr_inst = (state_q == FLUSH);

    // ---- registered state: performance counters ----
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (effective_p0)
                perf_br_q  <= perf_sat_inc(perf_br_q);
            if (mispredict_p0)
                perf_mis_q <= perf_sat_inc(perf_mis_q);
        end
    end

    assign bp.perf_branches    = perf_br_q;
    assign bp.perf_mispredicts = perf_mis_q;
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch resolver.
- Adds a bimodal predictor: a branch-history table (BHT) of 2-bit saturating counters.
- The decode stage receives a direction prediction and target. The execute stage resolves the branch, trains the BHT, raises a redirect only on mispredict, and squashes FLUSH_CYCLES wrong-path slots.
- Carries saturating branch/mispredict performance counters for debug.

Parameters:
- XLEN, 32, datapath width of PC, immediate and operands.
- BHT_ENTRIES, 64, BHT depth; power of two, ≥2.
- FLUSH_CYCLES, 1, cycles ignore_curr_inst stays high after a redirect; 1..15.
- PERF_W, 16, width of each performance counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode slot holds a conditional branch.
- dec_pc  in  XLEN  PC of the decode-stage branch.
- dec_imm  in  XLEN  sign-extended B-type immediate.
- pred_taken  out  1  predicted direction; combinational from dec_pc.
- pred_target  out  XLEN  dec_pc+dec_imm if pred_taken, else dec_pc+4.
- ex_valid  in  1  execute slot holds a branch to resolve.
- ex_pc  in  XLEN  PC of the resolving branch.
- ex_imm  in  XLEN  immediate of the resolving branch.
- rs1_val  in  XLEN  operand 1.
- rs2_val  in  XLEN  operand 2.
- branch_control  in  3  `BR_NOP/`BEQ/`BNE/`BLT/`BGE/`BLTU/`BGEU from processor_defines.
- ex_pred_taken  in  1  prediction carried down the pipe with this branch.
- pc_update_control  out  1  redirect fetch this cycle (mispredict).
- pc_update_val  out  XLEN  corrected PC; 0 when no redirect.
- ignore_curr_inst  out  1  squash the current wrong-path slot.
- perf_branches  out  PERF_W  resolved-branch count.
- perf_mispredicts  out  PERF_W  mispredict count.

Behaviour:
- Reset (i_rst low, asynchronous):
  - All BHT counters = 2'b01 (weakly not-taken).
  - Flush counter = 0, ignore_curr_inst = 0.
  - perf_branches = 0, perf_mispredicts = 0.
  - pc_update_control/pc_update_val follow the combinational rules below with internal state at reset values; with ex_valid=0 they are 0.
- Indexing:
  - idx = pc[log2(BHT_ENTRIES)+1 : 2].
  - The same function is used for dec_pc (lookup) and ex_pc (training).
- Predict (combinational, zero latency):
  - pred_taken = BHT[idx(dec_pc)][1] & dec_valid.
  - Adders wrap modulo 2^XLEN.
- Resolve (combinational):
  - effective = ex_valid & ~ignore_curr_inst & (branch_control != `BR_NOP).
  - actual taken uses the existing compare semantics: BLT/BGE signed; BLTU/BGEU unsigned.
  - Undefined branch_control codes: effective = 0.
  - mispredict = effective & (actual != ex_pred_taken).
  - pc_update_control = mispredict.
  - pc_update_val = actual ? ex_pc+ex_imm : ex_pc+4 when mispredict, else 0.
- Train (registered, on an edge where effective = 1):
  - BHT[idx(ex_pc)] increments if actual (saturate at 3), else decrements (saturate at 0).
  - Non-effective cycles leave the BHT unchanged.
- Same-index read/write: a dec_pc lookup on the training cycle sees the pre-update value; no bypass. The new value is visible the next cycle.
- Flush state machine, states IDLE and FLUSH, down-counter cnt:
  - IDLE → FLUSH on mispredict, with cnt = FLUSH_CYCLES.
  - In FLUSH: ignore_curr_inst = 1 and cnt decrements each cycle; FLUSH → IDLE when cnt reaches 1.
  - While in FLUSH, effective = 0, so no further redirect, training or counting. Back-to-back mispredicts therefore cannot occur.
  - ignore_curr_inst is registered: it rises the cycle after pc_update_control and is never high in the same cycle as it.
- Performance counters:
  - perf_branches += 1 per effective cycle.
  - perf_mispredicts += 1 per mispredict.
  - Both saturate at 2^PERF_W−1; no wrap.
- Reset mid-operation: asynchronously aborts FLUSH, clears all state, and drops ignore_curr_inst immediately.

Test Plan:
- Reset, then dec_valid=1, dec_pc=0x100, dec_imm=0x20 → pred_taken=0, pred_target=0x104.
- ex_valid=1, BEQ, rs1=rs2=5, ex_pc=0x100, ex_imm=0x20, ex_pred_taken=0 → same cycle: pc_update_control=1, pc_update_val=0x120. Next cycle: ignore_curr_inst=1, BHT[0] = 2'b10, perf_mispredicts=1.
- Repeat the taken BEQ at 0x100 four times with ex_pred_taken=1 after training → redirects occur only while prediction is wrong. Counter saturates at 3. Two not-taken resolutions then flip pred_taken to 0.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken. Each is checked against ex_pred_taken for redirect.
- FLUSH_CYCLES=3: mispredict, then ex_valid=1 with a mispredicting branch during the next 3 cycles → ignore_curr_inst high exactly 3 cycles; no redirect, BHT or perf change.
- Assert i_rst low mid-FLUSH → ignore_curr_inst, perf counters and the BHT return to reset values without waiting for a clock edge. PERF_W=2 with 5 branches → perf_branches holds 3.
